// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: FIFO read port (reb, data next cycle) to FWFT valid/ready stream via a DEPTH-entry prefetch ring; ports clk_i, rst_ni, fifo_rrdy_i/fifo_reb_o/fifo_dout_i, m_valid_o/m_ready_i/m_data_o, level_o, xfer_cnt_o
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         fifo_rrdy_i,
  output logic                         fifo_reb_o,
  input  logic [DATA_WIDTH-1:0]        fifo_dout_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [DATA_WIDTH-1:0]        m_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic [CNT_WIDTH-1:0]         xfer_cnt_o
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [LW-1:0] occ_q, occ_d;
  logic inflight_q;
  logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
  logic pop;
  always_comb begin
    fifo_reb_o = rst_ni && fifo_rrdy_i && ({1'b0, occ_q} + (LW+1)'(inflight_q) < (LW+1)'(DEPTH));
    m_valid_o = occ_q != '0;
    m_data_o = mem_q[rd_idx_q];
    pop = m_valid_o && m_ready_i;
    wr_idx_d = !inflight_q ? wr_idx_q : (wr_idx_q == IW'(DEPTH-1)) ? '0 : wr_idx_q + IW'(1);
    rd_idx_d = !pop ? rd_idx_q : (rd_idx_q == IW'(DEPTH-1)) ? '0 : rd_idx_q + IW'(1);
    occ_d = occ_q + LW'(inflight_q) - LW'(pop);
    xfer_cnt_d = pop ? xfer_cnt_q + CNT_WIDTH'(1) : xfer_cnt_q;
    level_o = occ_q;
    xfer_cnt_o = xfer_cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      occ_q <= '0;
      inflight_q <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      occ_q <= occ_d;
      inflight_q <= fifo_reb_o;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end
  always_ff @(posedge clk_i)
    if (inflight_q) mem_q[wr_idx_q] <= fifo_dout_i;
endmodule
